// File: rtl/mem_responder_pkg.sv
// Shared CPU definitions: bus widths, region select bit, opcodes, responder FSM encoding.
package risc_pkg;
   localparam int ADDR_W  = 13;
   localparam int DATA_W  = 8;
   localparam int SEL_BIT = 12;

   localparam logic [2:0] HLT = 3'd0;
   localparam logic [2:0] SKZ = 3'd1;
   localparam logic [2:0] ADD = 3'd2;
   localparam logic [2:0] AND = 3'd3;
   localparam logic [2:0] XOR = 3'd4;
   localparam logic [2:0] LDA = 3'd5;
   localparam logic [2:0] STO = 3'd6;
   localparam logic [2:0] JMP = 3'd7;

   typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_t;
   typedef enum logic [1:0] {SRC_NONE, SRC_ROM, SRC_RAM, SRC_UNMAP} src_t;

   // An in-region offset is mapped when no bit at or above the region's index width is set.
   function automatic logic in_map(input logic [SEL_BIT-1:0] offset, input int aw);
      return (offset >> aw) == '0;
   endfunction
endpackage

// File: rtl/mem_responder_if.sv
// CPU-side memory bus and ROM preload port; master = CPU controllers, slave = mem_responder.
interface mem_responder_if #(parameter int ROM_AW = 8);
   logic [risc_pkg::ADDR_W-1:0] addr;
   logic                        rd;
   logic                        wr;
   logic [risc_pkg::DATA_W-1:0] data_in;
   logic [risc_pkg::DATA_W-1:0] data_out;
   logic                        data_oe;
   logic                        ld_en;
   logic [ROM_AW-1:0]           ld_addr;
   logic [risc_pkg::DATA_W-1:0] ld_data;
   logic                        bus_err;

   modport master (output addr, rd, wr, data_in, ld_en, ld_addr, ld_data,
                   input  data_out, data_oe, bus_err);
   modport slave  (input  addr, rd, wr, data_in, ld_en, ld_addr, ld_data,
                   output data_out, data_oe, bus_err);
endinterface

// File: rtl/mem_responder_mem_array.sv
// Byte-wide memory with one synchronous write port and one synchronous (read-before-write) read port.
module mem_array
   import risc_pkg::*;
#(
   parameter int AW = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end
endmodule

// File: rtl/mem_responder.sv
// ROM/RAM bus responder: 1-cycle reads, edge-triggered single writes, sticky bus_err.
// Define WRPROT_EN to make the ROM region read-only from the bus (preload port still writes).
module mem_responder
   import risc_pkg::*;
#(
   parameter int ROM_AW = 8,
   parameter int RAM_AW = 8
) (
   input  logic               clk,
   input  logic               rst,
   mem_responder_if.slave     bus
);
   state_t            state_p0, state_nxt;
   src_t              src_p1, src_nxt;
   logic              wr_prev_p0, wr_armed_p0, bus_err_p0;
   logic              err_set, do_read, do_write, bus_rom_we, ram_we;
   logic              ram_sel, mapped, wr_rise, vld_p1;
   logic              rom_we;
   logic [ROM_AW-1:0] rom_waddr;
   logic [DATA_W-1:0] rom_wdata, rom_rdata, ram_rdata, data_out_c;

   assign ram_sel = bus.addr[SEL_BIT];
   assign mapped  = ram_sel ? in_map(bus.addr[SEL_BIT-1:0], RAM_AW)
                            : in_map(bus.addr[SEL_BIT-1:0], ROM_AW);
   // wr_armed stays low after reset until wr is seen low, so a held store is not replayed.
   assign wr_rise = bus.wr & ~wr_prev_p0 & wr_armed_p0;

   // p0: FSM decode of the current bus cycle
   always_comb begin
      state_nxt  = state_p0;
      src_nxt    = SRC_NONE;
      err_set    = 1'b0;
      do_read    = 1'b0;
      do_write   = 1'b0;
      bus_rom_we = 1'b0;
      ram_we     = 1'b0;
      if (bus.rd && bus.wr) begin
         state_nxt = IDLE;
         err_set   = 1'b1;
      end else begin
         case (state_p0)
            IDLE: begin
               if (bus.rd) begin
                  state_nxt = RD;
                  do_read   = 1'b1;
               end else if (bus.wr) begin
                  state_nxt = WR;
                  do_write  = wr_rise;
               end
            end
            RD:      if (bus.rd) do_read = 1'b1; else state_nxt = IDLE;
            WR:      if (!bus.wr) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
      if (do_read) begin
         if (!mapped) begin
            src_nxt = SRC_UNMAP;
            err_set = 1'b1;
         end else begin
            src_nxt = ram_sel ? SRC_RAM : SRC_ROM;
         end
      end
      if (do_write) begin
         if (!mapped)      err_set = 1'b1;
         else if (ram_sel) ram_we  = 1'b1;
         else begin
`ifdef WRPROT_EN
            err_set = 1'b1;
`else
            bus_rom_we = 1'b1;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_p0    <= IDLE;
         src_p1      <= SRC_NONE;
         wr_prev_p0  <= 1'b0;
         wr_armed_p0 <= 1'b0;
         bus_err_p0  <= 1'b0;
      end else begin
         state_p0    <= state_nxt;
         src_p1      <= src_nxt;
         wr_prev_p0  <= bus.wr;
         wr_armed_p0 <= wr_armed_p0 | ~bus.wr;
         if (err_set) bus_err_p0 <= 1'b1;
      end
   end

   // The preload port has priority; a coincident bus store to ROM is lost.
   assign rom_we    = bus.ld_en | bus_rom_we;
   assign rom_waddr = bus.ld_en ? bus.ld_addr : bus.addr[ROM_AW-1:0];
   assign rom_wdata = bus.ld_en ? bus.ld_data : bus.data_in;

   mem_array #(.AW(ROM_AW)) u_rom (
      .clk   (clk),
      .we    (rom_we),
      .waddr (rom_waddr),
      .wdata (rom_wdata),
      .raddr (bus.addr[ROM_AW-1:0]),
      .rdata (rom_rdata)
   );

   mem_array #(.AW(RAM_AW)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (bus.addr[RAM_AW-1:0]),
      .wdata (bus.data_in),
      .raddr (bus.addr[RAM_AW-1:0]),
      .rdata (ram_rdata)
   );

   // p1: select the registered read source
   always_comb begin
      case (src_p1)
         SRC_ROM:   data_out_c = rom_rdata;
         SRC_RAM:   data_out_c = ram_rdata;
         SRC_UNMAP: data_out_c = 8'hFF;
         default:   data_out_c = 8'h00;
      endcase
   end

   assign vld_p1       = (src_p1 != SRC_NONE);
   assign bus.data_out = data_out_c;
   assign bus.data_oe  = vld_p1;
   assign bus.bus_err  = bus_err_p0;
endmodule
